// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, 11-bit frame
// shifted on the device's falling clock edges, then acknowledge check.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned SETUP_CYCLES   = 100,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk_50,
    input  logic       areset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int unsigned PW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int unsigned WW        = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_INHIBIT      = 3'd1;
    localparam logic [2:0] S_RTS          = 3'd2;
    localparam logic [2:0] S_SHIFT        = 3'd3;
    localparam logic [2:0] S_WAIT_RELEASE = 3'd4;

    logic [2:0]    state;
    logic [9:0]    clk_hist;
    logic          dat_meta;
    logic          dat_sync;
    logic [9:0]    frame;
    logic [PW-1:0] phase_cnt;
    logic [3:0]    edge_cnt;
    logic [WW-1:0] wd_cnt;

    logic clk_fall;
    logic clk_sync;
    logic wd_expired;

    // History doubles as synchronizer; a fall needs five stable highs then five stable lows.
    assign clk_fall   = (clk_hist[9:5] == '1) && (clk_hist[4:0] == '0);
    assign clk_sync   = clk_hist[1];
    assign wd_expired = (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
    assign tx_ready   = (state == S_IDLE);

    always_ff @(posedge clk_50) begin
        if (areset) begin
            state      <= S_IDLE;
            clk_hist   <= '1;
            dat_meta   <= 1'b1;
            dat_sync   <= 1'b1;
            frame      <= '0;
            phase_cnt  <= '0;
            edge_cnt   <= '0;
            wd_cnt     <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            clk_hist <= {clk_hist[8:0], ps2_clk};
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;

            case (state)
                S_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (tx_valid) begin
                        frame      <= {1'b1, ~^tx_data, tx_data};
                        phase_cnt  <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (phase_cnt == PW'(INHIBIT_CYCLES - 1)) begin
                        phase_cnt  <= '0;
                        ps2_dat_oe <= 1'b1;
                        state      <= S_RTS;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                S_RTS: begin
                    if (phase_cnt == PW'(SETUP_CYCLES - 1)) begin
                        phase_cnt  <= '0;
                        ps2_clk_oe <= 1'b0;
                        edge_cnt   <= '0;
                        wd_cnt     <= '0;
                        state      <= S_SHIFT;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    // The ack decision is checked first so it wins over a simultaneous timeout.
                    if (clk_fall && (edge_cnt == 4'd10)) begin
                        tx_done    <= ~dat_sync;
                        tx_error   <= dat_sync;
                        ps2_dat_oe <= 1'b0;
                        edge_cnt   <= edge_cnt + 4'd1;
                        state      <= S_WAIT_RELEASE;
                    end else if (wd_expired) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        state      <= S_IDLE;
                    end else if (clk_fall) begin
                        ps2_dat_oe <= ~frame[edge_cnt];
                        edge_cnt   <= edge_cnt + 4'd1;
                    end
                end

                S_WAIT_RELEASE: begin
                    wd_cnt     <= wd_cnt + 1'b1;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (clk_sync && dat_sync) begin
                        state <= S_IDLE;
                    end else if (wd_expired) begin
                        tx_error <= 1'b1;
                        state    <= S_IDLE;
                    end
                end

                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: a PS/2 device model on the open-drain lines and an
// outcome scoreboard filled when each send is started.
module tb_ps2_host_tx;
    localparam int unsigned INH  = 50;
    localparam int unsigned SET  = 10;
    localparam int unsigned TMO  = 20000;
    localparam int unsigned HALF = 20;   // 1 us system clock -> 40 us device clock period

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         glitch;
        bit         busy;
        logic       exp_par;
    } vec_t;

    typedef struct {
        logic [10:0] bits;
        bit          check_bits;
        bit          done;
    } exp_t;

    logic       clk_50   = 1'b0;
    logic       areset   = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       tx_done;
    logic       tx_error;
    logic       dev_clk  = 1'b1;
    logic       dev_dat  = 1'b1;
    logic       ps2_clk;
    logic       ps2_dat;

    assign ps2_clk = dev_clk & ~ps2_clk_oe;
    assign ps2_dat = dev_dat & ~ps2_dat_oe;

    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          n_done = 0;
    int          n_err  = 0;
    bit          prev_pulse = 1'b0;
    logic [10:0] cap_bits = '0;
    exp_t        exp_q[$];
    vec_t        vecs[5];

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SET),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_50    (clk_50),
        .areset    (areset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    always #500 clk_50 = ~clk_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Completion monitor: every pulse must match the oldest pending expectation.
    always @(negedge clk_50) begin
        exp_t e;
        if (tx_done || tx_error) begin
            if (tx_done) n_done++;
            if (tx_error) n_err++;
            check("pulse_exclusive", 32'(tx_done & tx_error), 32'd0);
            check("pulse_width", 32'(prev_pulse), 32'd0);
            check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outcome_done", 32'(tx_done), 32'(e.done));
                if (e.check_bits) check("frame_bits", 32'(cap_bits), 32'(e.bits));
            end
        end
        prev_pulse = tx_done | tx_error;
    end

    task automatic start_tx(input logic [7:0] d);
        int c;
        @(negedge clk_50);
        check("ready_before", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_50);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        check("ready_low_T1", 32'(tx_ready), 32'd0);
        check("clk_oe_T1", 32'(ps2_clk_oe), 32'd1);
        check("dat_oe_T1", 32'(ps2_dat_oe), 32'd0);
        c = 0;
        while (!ps2_dat_oe && c < 10 * INH) begin
            @(negedge clk_50);
            c++;
        end
        check("inhibit_len", 32'(c), 32'(INH));
        c = 0;
        while (ps2_clk_oe && c < 10 * SET) begin
            @(negedge clk_50);
            c++;
        end
        check("setup_len", 32'(c), 32'(SET));
        check("start_on_line", 32'(ps2_dat), 32'd0);
    endtask

    task automatic device(input bit ack, input bit glitch, input bit busy, input bit abort);
        cap_bits[0] = ps2_dat;
        for (int k = 1; k <= 11; k++) begin
            for (int i = 0; i < HALF; i++) begin
                @(negedge clk_50);
                if (k == 11 && i == 0 && ack) dev_dat = 1'b0;
                if (glitch && k == 3 && i == 8) dev_clk = 1'b0;
                if (glitch && k == 3 && i == 11) dev_clk = 1'b1;
            end
            dev_clk = 1'b0;
            for (int i = 0; i < HALF; i++) begin
                @(negedge clk_50);
                if (busy && k == 2 && i == 12) begin
                    check("ready_busy", 32'(tx_ready), 32'd0);
                    tx_data  = 8'h55;
                    tx_valid = 1'b1;
                end
                if (busy && k == 2 && i == 13) begin
                    tx_valid = 1'b0;
                    tx_data  = 8'h00;
                end
                if (abort && k == 5 && i == 10) begin
                    check("pre_abort_dat_oe", 32'(ps2_dat_oe), 32'd1);
                    areset = 1'b1;
                    @(negedge clk_50);
                    check("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
                    check("abort_dat_oe", 32'(ps2_dat_oe), 32'd0);
                    check("abort_ready", 32'(tx_ready), 32'd1);
                    check("abort_done", 32'(tx_done), 32'd0);
                    check("abort_error", 32'(tx_error), 32'd0);
                    areset  = 1'b0;
                    dev_clk = 1'b1;
                    dev_dat = 1'b1;
                    repeat (20) @(negedge clk_50);
                    return;
                end
            end
            dev_clk = 1'b1;
            if (k <= 10) cap_bits[k] = ps2_dat;
        end
        dev_dat = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int c;
        int d0;
        int e0;
        d0 = n_done;
        e0 = n_err;
        exp_q.push_back('{bits: {1'b1, ~^v.data, v.data, 1'b0}, check_bits: 1'b1, done: v.ack});
        start_tx(v.data);
        device(v.ack, v.glitch, v.busy, 1'b0);
        c = 0;
        while (!tx_ready && c < 200) begin
            @(negedge clk_50);
            c++;
        end
        check("ready_return", 32'(tx_ready), 32'd1);
        check("end_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("end_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("parity_bit", 32'(cap_bits[9]), 32'(v.exp_par));
        check("done_count", 32'(n_done - d0), 32'(v.ack));
        check("error_count", 32'(n_err - e0), 32'(!v.ack));
    endtask

    initial begin
        #(64'd200_000_000);
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int c;
        int e0;
        vec_t post;

        vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1};

        repeat (3) @(negedge clk_50);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        areset = 1'b0;
        repeat (15) @(negedge clk_50);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            repeat (10) @(negedge clk_50);
        end

        // Device never clocks: watchdog fires a fixed time after the clock is released.
        e0 = n_err;
        exp_q.push_back('{bits: 11'h000, check_bits: 1'b0, done: 1'b0});
        start_tx(8'hAA);
        c = 0;
        while (!tx_error && c < TMO + 100) begin
            @(negedge clk_50);
            c++;
        end
        check("timeout_len", 32'(c), 32'(TMO));
        @(negedge clk_50);
        check("timeout_ready", 32'(tx_ready), 32'd1);
        check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("timeout_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("timeout_err_count", 32'(n_err - e0), 32'd1);
        repeat (10) @(negedge clk_50);

        // Reset after the fifth falling edge, then a clean send.
        start_tx(8'hED);
        device(1'b1, 1'b0, 1'b0, 1'b1);
        post = '{8'hF4, 1'b1, 1'b0, 1'b0, 1'b0};
        run_vec(post);

        repeat (20) @(negedge clk_50);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
